// File: rtl/norm_shift_register.sv
`timescale 1ns/1ps
// norm_shift_register
// WIDTH-bit load / shift-left register with an autonomous normalisation mode.
// In normalisation mode it shifts left until the MSB is 1 and reports how many
// shifts that took. This produces the leading-one-aligned operand and its
// shift amount for the multiplier/approximation datapath.
//
// Optional feature: define NORM_SHIFT_SERIAL_EN to add the serial_in port.
// Every shift then inserts serial_in at the LSB. Without the macro the LSB
// fill is always 0.
module norm_shift_register #(
  parameter int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             store,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift,
  input  logic             start,
`ifdef NORM_SHIFT_SERIAL_EN
  input  logic             serial_in,
`endif
  output logic [WIDTH-1:0] shifted,
  output logic [CNT_W-1:0] shift_count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic {
    IDLE = 1'b0,
    NORM = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shifted_q, shifted_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q, done_d;

  logic             fill;
  logic [WIDTH-1:0] shl_value;
  logic [CNT_W-1:0] count_inc;
  logic             msb_set;
  logic             next_is_last;
  logic             reg_is_zero;

`ifdef NORM_SHIFT_SERIAL_EN
  assign fill = serial_in;
`else
  assign fill = 1'b0;
`endif

  // The zero and MSB checks look at the register before any LSB insertion.
  // A fill bit therefore never changes whether a start needs to shift.
  assign shl_value    = {shifted_q[WIDTH-2:0], fill};
  assign count_inc    = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
  assign msb_set      = shifted_q[WIDTH-1];
  assign next_is_last = shifted_q[WIDTH-2];
  assign reg_is_zero  = (shifted_q == '0);

  // State register: all sequential state, with a synchronous reset to IDLE and
  // an empty register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shifted_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shifted_q <= shifted_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: the command priority in IDLE is store, then start, then
  // shift. In NORM the block keeps shifting until the leading one reaches
  // the MSB.
  always_comb begin
    state_d   = state_q;
    shifted_d = shifted_q;
    count_d   = count_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (store) begin
          shifted_d = data_in;
          count_d   = '0;
        end else if (start) begin
          if (msb_set || reg_is_zero) begin
            // The value is already aligned, or it can never be aligned.
            count_d = '0;
            done_d  = 1'b1;
          end else begin
            // The first shift happens on the start edge itself.
            shifted_d = shl_value;
            count_d   = CNT_W'(1);
            if (next_is_last) begin
              done_d = 1'b1;
            end else begin
              state_d = NORM;
            end
          end
        end else if (shift) begin
          shifted_d = shl_value;
          count_d   = count_inc;
        end
      end

      NORM: begin
        // User commands are ignored here. The register always holds a nonzero
        // value with MSB 0, so this loop always terminates.
        shifted_d = shl_value;
        count_d   = count_inc;
        if (next_is_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: drive the register view and the status flags from the
  // current state.
  always_comb begin
    shifted     = shifted_q;
    shift_count = count_q;
    busy        = (state_q == NORM);
    done        = done_q;
    zero        = (shifted_q == '0);
  end

endmodule

// File: tb/tb_norm_shift_register.sv
`timescale 1ns/1ps
// Scoreboard bench for norm_shift_register. The stimulus pushes expected
// results into queues. A separate monitor pops an entry and compares it on
// every done pulse, and for manual operations on each snapshot strobe.
module tb_norm_shift_register;

  localparam int W    = 16;
  localparam int CW   = $clog2(W + 1);
  localparam int CMAX = (1 << CW) - 1;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          store   = 1'b0;
  logic          shift   = 1'b0;
  logic          start   = 1'b0;
  logic [W-1:0]  data_in = '0;
`ifdef NORM_SHIFT_SERIAL_EN
  logic          serial_in = 1'b0;
`endif
  logic [W-1:0]  shifted;
  logic [CW-1:0] shift_count;
  logic          busy;
  logic          done;
  logic          zero;

  always #5 clk = ~clk;

  norm_shift_register #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .store       (store),
    .data_in     (data_in),
    .shift       (shift),
    .start       (start),
`ifdef NORM_SHIFT_SERIAL_EN
    .serial_in   (serial_in),
`endif
    .shifted     (shifted),
    .shift_count (shift_count),
    .busy        (busy),
    .done        (done),
    .zero        (zero)
  );

  typedef struct {
    logic [W-1:0] val;
    int           cnt;
    int           busy_n;
    string        tag;
  } exp_t;

  exp_t         norm_q[$];
  exp_t         snap_q[$];
  int           n_cmp    = 0;
  int           n_err    = 0;
  int           busy_cnt = 0;
  logic         obs      = 1'b0;
  logic [W-1:0] m_val    = '0;
  int           m_cnt    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: the number of leading zeros. A zero value counts as already aligned.
  function automatic int lead_zeros(input logic [W-1:0] v);
    int k = 0;
    if (v == '0) return 0;
    while (v[W-1-k] == 1'b0) k++;
    return k;
  endfunction

  function automatic logic fill_bit();
`ifdef NORM_SHIFT_SERIAL_EN
    return serial_in;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    obs = 1'b0;
  endtask

  task automatic snap(input string tag);
    exp_t e;
    e.val    = m_val;
    e.cnt    = m_cnt;
    e.busy_n = 0;
    e.tag    = tag;
    snap_q.push_back(e);
    obs = 1'b1;
    $display("txn %-10s expect shifted=%04h count=%0d", tag, m_val, m_cnt);
  endtask

  task automatic do_store(input logic [W-1:0] d, input string tag);
    data_in = d;
    store   = 1'b1;
    tick();
    store = 1'b0;
    m_val = d;
    m_cnt = 0;
    snap(tag);
  endtask

  task automatic do_shift(input logic s, input string tag);
    logic f;
`ifdef NORM_SHIFT_SERIAL_EN
    serial_in = s;
`else
    if (s) begin end
`endif
    f     = fill_bit();
    shift = 1'b1;
    tick();
    shift = 1'b0;
    m_val = (m_val << 1) | W'(f);
    m_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
    snap(tag);
  endtask

  task automatic do_store_shift(input logic [W-1:0] d, input string tag);
    data_in = d;
    store   = 1'b1;
    shift   = 1'b1;
    tick();
    store = 1'b0;
    shift = 1'b0;
    m_val = d;
    m_cnt = 0;
    snap(tag);
  endtask

  task automatic do_start(input string tag, input bit poke);
    exp_t e;
    int   k;
    bit   got;
    k = lead_zeros(m_val);
    e.val    = m_val << k;
    e.cnt    = k;
    e.busy_n = (k > 0) ? k - 1 : 0;
    e.tag    = tag;
    norm_q.push_back(e);
    $display("txn %-10s start on %04h expect %04h count=%0d", tag, m_val, e.val, k);
`ifdef NORM_SHIFT_SERIAL_EN
    serial_in = 1'b0;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (poke && busy) begin
        data_in = W'($urandom);
        store   = 1'($urandom_range(0, 1));
        shift   = 1'($urandom_range(0, 1));
        start   = 1'($urandom_range(0, 1));
      end
      tick();
      store = 1'b0;
      shift = 1'b0;
      start = 1'b0;
    end
    if (!got) begin
      chk({tag, "_timeout"}, 32'(done), 32'd1);
      norm_q.delete();
    end
    m_val = e.val;
    m_cnt = k;
  endtask

  // Monitor: counts busy cycles and checks the queued results when the DUT
  // pulses done or when a snapshot is strobed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) busy_cnt = 0;
      else if (busy) busy_cnt++;
      if (done) begin
        if (norm_q.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          e = norm_q.pop_front();
          chk({e.tag, "_val"},   32'(shifted),     32'(e.val));
          chk({e.tag, "_cnt"},   32'(shift_count), 32'(e.cnt));
          chk({e.tag, "_zero"},  32'(zero),        32'(e.val == '0));
          chk({e.tag, "_busyn"}, 32'(busy_cnt),    32'(e.busy_n));
        end
        busy_cnt = 0;
      end
      if (obs && snap_q.size() > 0) begin
        e = snap_q.pop_front();
        chk({e.tag, "_val"},  32'(shifted),     32'(e.val));
        chk({e.tag, "_cnt"},  32'(shift_count), 32'(e.cnt));
        chk({e.tag, "_busy"}, 32'(busy),        32'd0);
        chk({e.tag, "_done"}, 32'(done),        32'd0);
        chk({e.tag, "_zero"}, 32'(zero),        32'(e.val == '0));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] d;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    m_val = '0;
    m_cnt = 0;
    snap("reset");

    do_store(16'h0013, "st13");
    do_start("norm13", 1'b1);
    do_store(16'h8001, "st8001");
    do_start("norm8001", 1'b0);
    do_store(16'h0000, "st0");
    do_start("norm0", 1'b0);
    do_store(16'h4000, "st4000");
    do_start("norm4000", 1'b0);
    do_store(16'h0001, "st1");
    repeat (3) do_shift(1'b0, "shl");
    do_store_shift(16'h00F0, "stshl");
    do_store(16'h0001, "sat_st");
    repeat (40) do_shift(1'b0, "sat_shl");

    // Reset in the fifth busy cycle.
    do_store(16'h0001, "rst_st");
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("rst_busy5", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_val = '0;
    m_cnt = 0;
    snap("rst_mid");
    repeat (20) tick();

`ifdef NORM_SHIFT_SERIAL_EN
    do_store(16'h0001, "ser_st");
    repeat (3) do_shift(1'b1, "ser_shl");
`endif

    for (int n = 0; n < 150; n++) begin
      d = W'(($urandom & 32'hFFFF) >> $urandom_range(0, 16));
      case ($urandom_range(0, 4))
        0: do_store(d, "r_store");
        1: do_shift(1'($urandom_range(0, 1)), "r_shift");
        2: do_store_shift(d, "r_stshl");
        default: begin
          if ($urandom_range(0, 1) == 1) do_store(d, "r_store");
          do_start("r_norm", 1'b1);
        end
      endcase
    end

    repeat (5) tick();
    chk("leftover_norm", 32'(norm_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/norm_shift_register.md
# norm_shift_register

Parametrised successor of the 16- and 32-bit load/shift-left registers. It holds a WIDTH-bit operand and supports single-step manual left shifts. It also provides an autonomous normalisation mode, which shifts left until the MSB is 1 and reports the shift count. It sits in the operand path ahead of the multiplier/approximation datapath, where a leading-one-aligned operand and its shift amount are needed.

## Interface
Parameters:
- WIDTH, 16, register width in bits; legal values are 2 and up.
- CNT_W, $clog2(WIDTH+1), width of the shift counter; this is a derived localparam and is not overridden.

Ports:
- clk  input  1  rising-edge clock; the block uses one clock.
- rst  input  1  synchronous, active-high reset.
- store  input  1  load data_in into the register.
- data_in  input  WIDTH  operand to load.
- shift  input  1  perform one manual left shift by 1.
- start  input  1  begin normalisation of the current register contents.
- serial_in  input  1  LSB fill bit; present only with NORM_SHIFT_SERIAL_EN.
- shifted  output  WIDTH  register contents.
- shift_count  output  CNT_W  number of left shifts since the last store or start.
- busy  output  1  normalisation in progress.
- done  output  1  one-cycle pulse marking the end of normalisation.
- zero  output  1  combinational (shifted == 0).

## Operation
- FSM states are IDLE and NORM; the reset state is IDLE.
- Reset values: shifted=0, shift_count=0, busy=0, done=0, so zero=1.
- Priority in IDLE: store, then start, then shift.
- store: shifted <= data_in; shift_count <= 0.
- shift: shifted <= {shifted[WIDTH-2:0], fill}; shift_count increments and saturates at 2^CNT_W-1.
- start when shifted[WIDTH-1]=1 or shifted==0: no shift is performed, shift_count <= 0, done=1 in the next cycle, and the state stays IDLE.
- start otherwise: shift_count <= 1, the first shift happens on the same edge, and the state moves to NORM with busy=1.
  - Exception: if the pre-shift shifted[WIDTH-2]=1, the single shift completes normalisation. The state stays IDLE and done=1 in the next cycle.
- NORM, on each edge: shift left by 1 and increment shift_count.
  - If the pre-shift shifted[WIDTH-2]=1, that shift is the last one: the state returns to IDLE, busy <= 0, done <= 1.
- In NORM, store, start and shift are ignored and have no side effects.
- done is high for exactly one cycle per start and is otherwise 0.
- fill = serial_in with the macro enabled, 0 without it.
- Arithmetic:
  - The register is unsigned, and bits shifted out of the MSB are discarded.
  - For an operand with k leading zeros, the final shift_count is k, which is always at most WIDTH-1.

## Timing
- Manual store and shift take effect at the next rising edge, with a latency of 1.
- Normalisation of a value with k leading zeros (1 ≤ k ≤ WIDTH-1), with start sampled at edge E0:
  - Shifts occur on edges E0 … E(k-1).
  - busy is high after E0 through E(k-1) exclusive.
  - done is high during the cycle after E(k-1).
- Normalisation with k=0, or of a zero value: done is high during the cycle after E0; busy never rises.
- A new start is accepted on the edge at which done is high, because the FSM is already in IDLE.
- rst asserted mid-normalisation returns all outputs to their reset values at that edge; no done is issued.
- zero follows shifted combinationally, with no extra latency.

## Configuration
- NORM_SHIFT_SERIAL_EN defined:
  - The serial_in port exists.
  - Every manual and normalising shift inserts serial_in at the LSB.
  - The zero/MSB checks at start use the register value before any insertion.
- NORM_SHIFT_SERIAL_EN undefined: serial_in is absent, and the LSB fill is always 0.

## Test plan
- Reset, then observe the outputs: shifted=0x0000, shift_count=0, busy=0, done=0, zero=1.
- Store 0x0013, then pulse start:
  - busy is high after the start edge; 11 shifts occur.
  - Then shifted=0x9800, shift_count=11, and done is high for exactly one cycle.
  - store and shift pulses while busy have no effect.
- Store 0x8001, then pulse start: done is high in the next cycle, busy stays 0, shifted=0x8001, shift_count=0.
- Store 0x0000, then pulse start: done is high in the next cycle, zero=1, shift_count=0.
- Store 0x4000, then pulse start: done is high in the next cycle, busy stays 0, shifted=0x8000, shift_count=1.
- Store 0x0001, then pulse shift for 3 cycles: shifted=0x0008, shift_count=3.
- Assert store and shift in the same cycle with data_in=0x00F0: the result is shifted=0x00F0 and shift_count=0, because store wins.
- Store 0x0001, pulse start, and assert rst at the 5th busy cycle: after that edge, all outputs equal their reset values and no done pulse appears.
- With NORM_SHIFT_SERIAL_EN defined: store 0x0001, pulse shift 3× with serial_in=1, giving shifted=0x000F and shift_count=3.
